// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with terminal-count pulse and optional auto-reload.
module down_counter_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Load,
  input  logic             Enabled,
  input  logic             Autoreload,
  input  logic [WIDTH-1:0] Loadvalue,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PAUSE = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic             done_q,    done_d;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath: Load first, then count/terminal step, else hold.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    done_d    = 1'b0;

    if (Load) begin
      counter_d = Loadvalue;
      reload_d  = Loadvalue;
      state_d   = (Loadvalue == '0) ? IDLE : PAUSE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        PAUSE, RUN: begin
          if (Enabled) begin
            if (counter_q == WIDTH'(1)) begin
              // Terminal edge: Autoreload is only looked at here.
              done_d = 1'b1;
              if (Autoreload) begin
                counter_d = reload_q;
                state_d   = RUN;
              end else begin
                counter_d = '0;
                state_d   = DONE;
              end
            end else if (counter_q == '0) begin
              // Unreachable by construction; park safely rather than wrap.
              state_d = IDLE;
            end else begin
              counter_d = counter_q - WIDTH'(1);
              state_d   = RUN;
            end
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          counter_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign counter = counter_q;
  assign zero    = (counter_q == '0);
  assign done    = done_q;
  assign state   = state_q;

endmodule
